// File: rtl/spad_result_writeback.sv
// Result writeback engine: buffers finished result rows in a small FIFO and
// streams them to DDR over the MIG AW/W/B channels. A job of row_cnt_i rows
// is cut into bursts of at most MAX_BURST beats. Only one burst is in flight
// at a time: the next AW waits for the previous burst's B response.
module spad_result_writeback #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 1024,
    parameter int REG_WIDTH  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [REG_WIDTH-1:0]    row_cnt_i,
    input  logic [DATA_WIDTH-1:0]   res_data_i,
    input  logic                    res_valid_i,
    output logic                    res_ready_o,
    output logic [ADDR_WIDTH-1:0]   mig_addr_o,
    output logic                    mig_awvalid_o,
    output logic                    mig_arvalid_o,
    output logic [7:0]              mig_arwlen_o,
    input  logic                    mig_awready_i,
    output logic                    mig_wvalid_o,
    output logic [DATA_WIDTH-1:0]   mig_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mig_wstrb_o,
    output logic                    mig_wlast_o,
    input  logic                    mig_wready_i,
    input  logic                    mig_bvalid_i,
    output logic                    mig_bready_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [REG_WIDTH-1:0]    rows_left_reg;
    logic [REG_WIDTH-1:0]    rows_to_accept_reg;
    logic [7:0]              len_reg;
    logic [7:0]              beat_reg;
    logic                    awvalid_reg;
    logic                    bready_reg;
    logic                    busy_reg;
    logic                    done_reg;

    // Result FIFO storage and pointers (extra MSB distinguishes full/empty)
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr_reg;
    logic [PTR_W:0]          rd_ptr_reg;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [DATA_WIDTH-1:0]   fifo_head;

    logic                    push;
    logic                    pop;
    logic                    w_valid;
    logic [8:0]              burst_beats;
    logic [REG_WIDTH-1:0]    rows_after;
    logic [ADDR_WIDTH-1:0]   addr_step;

    // Burst length field (beats-1) for a given number of remaining rows.
    function automatic logic [7:0] burst_len(input logic [REG_WIDTH-1:0] rows);
        if (rows > REG_WIDTH'(MAX_BURST)) begin
            return 8'(MAX_BURST - 1);
        end else begin
            return 8'(rows - REG_WIDTH'(1));
        end
    endfunction

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

    assign res_ready_o = busy_reg & ~fifo_full & (rows_to_accept_reg != '0);
    assign push        = res_valid_i & res_ready_o;
    assign w_valid     = (state_reg == S_W) & ~fifo_empty;
    assign pop         = w_valid & mig_wready_i;

    // Size of the current burst and the job bookkeeping after it completes.
    assign burst_beats = {1'b0, len_reg} + 9'd1;
    assign rows_after  = rows_left_reg - REG_WIDTH'(burst_beats);
    assign addr_step   = ADDR_WIDTH'(burst_beats) * BEAT_BYTES;

    assign mig_addr_o    = addr_reg;
    assign mig_awvalid_o = awvalid_reg;
    assign mig_arvalid_o = 1'b0;
    assign mig_arwlen_o  = len_reg;
    assign mig_wvalid_o  = w_valid;
    assign mig_wlast_o   = w_valid & (beat_reg == len_reg);
    assign mig_bready_o  = bready_reg;
    assign busy_o        = busy_reg;
    assign done_o        = done_reg;

    // Per byte lane: strobe follows wvalid, data is forced to zero when idle.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        assign mig_wstrb_o[gi]         = w_valid;
        assign mig_wdata_o[gi*8 +: 8]  = fifo_head[gi*8 +: 8] & {8{w_valid}};
    end

    // FIFO storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= res_data_i;
        end
    end

    // FIFO pointer update; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
            end
        end
    end

    // Count of rows still to accept from compute; blocks rows beyond the job.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rows_to_accept_reg <= '0;
        end else if (state_reg == S_IDLE && start_i) begin
            rows_to_accept_reg <= row_cnt_i;
        end else if (push) begin
            rows_to_accept_reg <= rows_to_accept_reg - REG_WIDTH'(1);
        end
    end

    // Job sequencer: AW -> W beats -> B per burst, then a one-cycle done pulse.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            rows_left_reg <= '0;
            len_reg       <= '0;
            beat_reg      <= '0;
            awvalid_reg   <= 1'b0;
            bready_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        busy_reg      <= 1'b1;
                        addr_reg      <= base_addr_i;
                        rows_left_reg <= row_cnt_i;
                        if (row_cnt_i == '0) begin
                            state_reg <= S_DONE;
                        end else begin
                            state_reg   <= S_AW;
                            awvalid_reg <= 1'b1;
                            len_reg     <= burst_len(row_cnt_i);
                        end
                    end
                end
                S_AW: begin
                    if (mig_awready_i) begin
                        awvalid_reg <= 1'b0;
                        beat_reg    <= '0;
                        state_reg   <= S_W;
                    end
                end
                S_W: begin
                    if (pop) begin
                        if (beat_reg == len_reg) begin
                            bready_reg <= 1'b1;
                            state_reg  <= S_B;
                        end else begin
                            beat_reg <= beat_reg + 8'd1;
                        end
                    end
                end
                S_B: begin
                    if (mig_bvalid_i) begin
                        bready_reg    <= 1'b0;
                        addr_reg      <= addr_reg + addr_step;
                        rows_left_reg <= rows_after;
                        if (rows_after != '0) begin
                            state_reg   <= S_AW;
                            awvalid_reg <= 1'b1;
                            len_reg     <= burst_len(rows_after);
                        end else begin
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spad_result_writeback.sv
// Testbench for spad_result_writeback: random job stimulus scored against a
// burst/row model built from the job parameters, one line printed per job.
module tb_spad_result_writeback;

    localparam int AW = 32;
    localparam int DW = 1024;
    localparam int RW = 32;
    localparam int FD = 16;
    localparam int MB = 64;
    localparam int SW = DW / 8;
    localparam int BB = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [RW-1:0] row_cnt_i;
    logic [DW-1:0] res_data_i;
    logic          res_valid_i;
    logic          res_ready_o;
    logic [AW-1:0] mig_addr_o;
    logic          mig_awvalid_o;
    logic          mig_arvalid_o;
    logic [7:0]    mig_arwlen_o;
    logic          mig_awready_i;
    logic          mig_wvalid_o;
    logic [DW-1:0] mig_wdata_o;
    logic [SW-1:0] mig_wstrb_o;
    logic          mig_wlast_o;
    logic          mig_wready_i;
    logic          mig_bvalid_i;
    logic          mig_bready_o;
    logic          busy_o;
    logic          done_o;

    spad_result_writeback #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .REG_WIDTH  (RW),
        .FIFO_DEPTH (FD),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .row_cnt_i     (row_cnt_i),
        .res_data_i    (res_data_i),
        .res_valid_i   (res_valid_i),
        .res_ready_o   (res_ready_o),
        .mig_addr_o    (mig_addr_o),
        .mig_awvalid_o (mig_awvalid_o),
        .mig_arvalid_o (mig_arvalid_o),
        .mig_arwlen_o  (mig_arwlen_o),
        .mig_awready_i (mig_awready_i),
        .mig_wvalid_o  (mig_wvalid_o),
        .mig_wdata_o   (mig_wdata_o),
        .mig_wstrb_o   (mig_wstrb_o),
        .mig_wlast_o   (mig_wlast_o),
        .mig_wready_i  (mig_wready_i),
        .mig_bvalid_i  (mig_bvalid_i),
        .mig_bready_o  (mig_bready_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fails  = 0;

    // Results of the most recent job, for scenario-level checks.
    int r_aw;
    int r_beats;
    int r_accepted;
    int r_max_fill;

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Runs one job: drives start, rows and MIG responses cycle by cycle at the
    // falling edge and scores every output against the job model.
    task automatic run_job(input logic [AW-1:0] base, input int cnt, input int valid_pct,
                           input int wready_mode, input int aw_delay, input int bvalid_pct,
                           input int extra_rows, input int restart_at, input int abort_beats,
                           input string tag);
        logic [AW-1:0] exp_addr_q[$];
        logic [7:0]    exp_len_q[$];
        logic [DW-1:0] row_q[$];
        logic [DW-1:0] exp_data_q[$];
        logic [AW-1:0] a;
        logic [AW-1:0] stall_addr;
        logic [7:0]    stall_len;
        logic [7:0]    cur_len;
        logic [DW-1:0] stall_data;
        logic          busy_exp;
        logic          ready_ok;
        int rem, b, cyc;
        int offered, fill, beat, aw_wait, done_at;
        bit in_burst, w_done, finished, aborted, aw_stall, w_stall;

        // Model: burst list from the job length and base address
        a = base;
        rem = cnt;
        while (rem > 0) begin
            b = (rem > MB) ? MB : rem;
            exp_addr_q.push_back(a);
            exp_len_q.push_back(8'(b - 1));
            a = a + AW'(b * BB);
            rem -= b;
        end
        for (int i = 0; i < cnt + extra_rows; i++) row_q.push_back(rand_row());

        offered = 0; fill = 0; beat = 0; aw_wait = 0;
        done_at = (cnt == 0) ? 2 : -1;
        in_burst = 0; w_done = 0; finished = 0; aborted = 0; aw_stall = 0; w_stall = 0;
        cur_len = '0; stall_addr = '0; stall_len = '0; stall_data = '0;
        r_aw = 0; r_beats = 0; r_accepted = 0; r_max_fill = 0;

        @(negedge clk_i);
        start_i = 1'b1;
        base_addr_i = base;
        row_cnt_i = RW'(cnt);
        @(negedge clk_i);
        start_i = 1'b0;
        base_addr_i = $urandom;
        row_cnt_i = $urandom;
        cyc = 1;

        while (cyc <= 3000 && !finished && !aborted) begin
            // ---- output checks ----
            busy_exp = (done_at < 0) || (cyc < done_at);
            n_checks++;
            if (busy_o !== busy_exp) begin
                n_fails++;
                $display("FAIL %s busy cyc=%0d: got %b expected %b", tag, cyc, busy_o, busy_exp);
            end
            n_checks++;
            if (done_o !== (cyc == done_at)) begin
                n_fails++;
                $display("FAIL %s done cyc=%0d: got %b expected %b", tag, cyc, done_o, (cyc == done_at));
            end
            n_checks++;
            if (mig_arvalid_o !== 1'b0) begin
                n_fails++;
                $display("FAIL %s arvalid: got %b expected 0", tag, mig_arvalid_o);
            end
            ready_ok = busy_exp && (fill < FD) && (offered < cnt);
            n_checks++;
            if (res_ready_o !== 1'b0 && !ready_ok) begin
                n_fails++;
                $display("FAIL %s res_ready cyc=%0d: got %b expected 0 (fill=%0d accepted=%0d)",
                         tag, cyc, res_ready_o, fill, offered);
            end
            if (aw_stall) begin
                n_checks++;
                if (mig_awvalid_o !== 1'b1 || mig_addr_o !== stall_addr || mig_arwlen_o !== stall_len) begin
                    n_fails++;
                    $display("FAIL %s aw_hold: got v=%b a=%h l=%0d expected v=1 a=%h l=%0d",
                             tag, mig_awvalid_o, mig_addr_o, mig_arwlen_o, stall_addr, stall_len);
                end
            end
            if (mig_awvalid_o === 1'b1) begin
                n_checks++;
                if (in_burst || exp_addr_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL %s aw_unexpected cyc=%0d: got awvalid=1 expected 0", tag, cyc);
                end else if (mig_addr_o !== exp_addr_q[0] || mig_arwlen_o !== exp_len_q[0]) begin
                    n_fails++;
                    $display("FAIL %s aw_fields: got addr=%h len=%0d expected addr=%h len=%0d",
                             tag, mig_addr_o, mig_arwlen_o, exp_addr_q[0], exp_len_q[0]);
                end
            end
            if (w_stall) begin
                n_checks++;
                if (mig_wvalid_o !== 1'b1 || mig_wdata_o !== stall_data) begin
                    n_fails++;
                    $display("FAIL %s w_hold: got wvalid=%b data=%h expected wvalid=1 data=%h",
                             tag, mig_wvalid_o, mig_wdata_o[63:0], stall_data[63:0]);
                end
            end
            n_checks++;
            if (mig_wvalid_o === 1'b1) begin
                if (!in_burst || w_done || exp_data_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL %s w_unexpected cyc=%0d: got wvalid=1 expected 0", tag, cyc);
                end else if (mig_wdata_o !== exp_data_q[0] || mig_wlast_o !== (8'(beat) == cur_len) ||
                             mig_wstrb_o !== '1) begin
                    n_fails++;
                    $display("FAIL %s w_beat: got data=%h last=%b expected data=%h last=%b strb all ones",
                             tag, mig_wdata_o[63:0], mig_wlast_o, exp_data_q[0][63:0], (8'(beat) == cur_len));
                end
            end else if (mig_wlast_o !== 1'b0 || mig_wstrb_o !== '0) begin
                n_fails++;
                $display("FAIL %s w_idle: got wlast=%b strb_or=%b expected 0", tag, mig_wlast_o, |mig_wstrb_o);
            end
            n_checks++;
            if (mig_bready_o !== w_done) begin
                n_fails++;
                $display("FAIL %s bready cyc=%0d: got %b expected %b", tag, cyc, mig_bready_o, w_done);
            end

            // ---- drive inputs for the coming rising edge ----
            start_i = (cyc == restart_at);
            if (cyc == restart_at) begin
                base_addr_i = base ^ 32'h0010_0000;
                row_cnt_i = 7;
            end
            if (offered < row_q.size() && $urandom_range(99) < valid_pct) begin
                res_valid_i = 1'b1;
                res_data_i = row_q[offered];
            end else begin
                res_valid_i = 1'b0;
                res_data_i = rand_row();
            end
            if (mig_awvalid_o === 1'b1) begin
                aw_wait++;
                mig_awready_i = (aw_wait > aw_delay);
            end else begin
                aw_wait = 0;
                mig_awready_i = 1'b0;
            end
            case (wready_mode)
                0: mig_wready_i = 1'b1;
                1: mig_wready_i = 1'($urandom_range(1));
                default: mig_wready_i = (cyc >= 40) ? 1'(cyc % 2) : 1'b0;
            endcase
            mig_bvalid_i = w_done && ($urandom_range(99) < bvalid_pct);

            // ---- model update from this cycle's handshakes ----
            aw_stall = mig_awvalid_o && !mig_awready_i;
            stall_addr = mig_addr_o;
            stall_len = mig_arwlen_o;
            w_stall = mig_wvalid_o && !mig_wready_i;
            stall_data = mig_wdata_o;
            if (res_valid_i && res_ready_o) begin
                exp_data_q.push_back(row_q[offered]);
                offered++;
                fill++;
            end
            if (mig_wvalid_o && mig_wready_i && in_burst && !w_done && exp_data_q.size() > 0) begin
                void'(exp_data_q.pop_front());
                fill--;
                r_beats++;
                if (8'(beat) == cur_len) w_done = 1;
                else beat++;
            end
            if (mig_awvalid_o && mig_awready_i && !in_burst && exp_len_q.size() > 0) begin
                cur_len = exp_len_q.pop_front();
                void'(exp_addr_q.pop_front());
                in_burst = 1;
                w_done = 0;
                beat = 0;
                r_aw++;
            end else if (w_done && mig_bvalid_i && mig_bready_o) begin
                in_burst = 0;
                w_done = 0;
                if (exp_addr_q.size() == 0) done_at = cyc + 2;
            end
            if (fill > r_max_fill) r_max_fill = fill;
            r_accepted = offered;
            if (abort_beats > 0 && r_beats >= abort_beats) aborted = 1;
            if (done_at >= 0 && cyc >= done_at + 2) finished = 1;
            if (!finished && !aborted) begin
                @(negedge clk_i);
                cyc++;
            end
        end

        if (!aborted) begin
            n_checks++;
            if (!finished) begin
                n_fails++;
                $display("FAIL %s timeout: got no completion in 3000 cycles expected done", tag);
            end
            n_checks++;
            if (r_beats != cnt || r_accepted != cnt || exp_addr_q.size() != 0) begin
                n_fails++;
                $display("FAIL %s totals: got beats=%0d accepted=%0d aw_left=%0d expected %0d/%0d/0",
                         tag, r_beats, r_accepted, exp_addr_q.size(), cnt, cnt);
            end
            res_valid_i = 1'b0;
            mig_bvalid_i = 1'b0;
            mig_awready_i = 1'b0;
        end
        $display("job %s: base=%h rows=%0d aw=%0d beats=%0d max_fill=%0d%s",
                 tag, base, cnt, r_aw, r_beats, r_max_fill, aborted ? " (aborted)" : "");
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({mig_awvalid_o, mig_arvalid_o, mig_wvalid_o, mig_wlast_o, mig_bready_o,
             busy_o, done_o, res_ready_o} !== 8'b0) begin
            n_fails++;
            $display("FAIL reset ctrl: got %b expected 00000000", {mig_awvalid_o, mig_arvalid_o,
                     mig_wvalid_o, mig_wlast_o, mig_bready_o, busy_o, done_o, res_ready_o});
        end
        n_checks++;
        if (mig_addr_o !== '0 || mig_arwlen_o !== '0 || mig_wstrb_o !== '0 || mig_wdata_o !== '0) begin
            n_fails++;
            $display("FAIL reset data: got addr=%h len=%0d expected 0", mig_addr_o, mig_arwlen_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_burst();
        run_job(32'h0000_1000, 4, 100, 0, 0, 100, 0, 0, 0, "single");
        n_checks++;
        if (r_aw != 1) begin
            n_fails++;
            $display("FAIL single aw_count: got %0d expected 1", r_aw);
        end
    endtask

    task automatic test_multi_burst();
        run_job(32'h0, 150, 100, 0, 0, 100, 0, 0, 0, "multi");
        n_checks++;
        if (r_aw != 3) begin
            n_fails++;
            $display("FAIL multi aw_count: got %0d expected 3", r_aw);
        end
    endtask

    task automatic test_backpressure();
        run_job(32'h0002_0000, 100, 70, 2, 5, 60, 0, 0, 0, "backpressure");
        n_checks++;
        if (r_max_fill != FD) begin
            n_fails++;
            $display("FAIL backpressure fill: got max %0d expected %0d", r_max_fill, FD);
        end
        run_job(32'h0004_0000, 90, 50, 1, 2, 50, 0, 0, 0, "random_ready");
    endtask

    task automatic test_zero_length();
        run_job(32'hDEAD_0000, 0, 100, 0, 0, 100, 0, 0, 0, "zero_len");
        n_checks++;
        if (r_aw != 0) begin
            n_fails++;
            $display("FAIL zero_len aw_count: got %0d expected 0", r_aw);
        end
    endtask

    task automatic test_extra_input();
        run_job(32'h0000_3000, 3, 100, 1, 1, 100, 2, 3, 0, "extra_rows");
        n_checks++;
        if (r_accepted != 3) begin
            n_fails++;
            $display("FAIL extra_rows accepted: got %0d expected 3", r_accepted);
        end
    endtask

    task automatic test_burst_boundaries();
        run_job(32'h0001_0000, 64, 100, 0, 0, 100, 0, 0, 0, "exact_64");
        run_job(32'h0001_0000, 65, 80, 1, 0, 100, 0, 0, 0, "len_65");
        run_job(32'h0001_0000, 1, 100, 0, 0, 100, 0, 0, 0, "one_row");
        run_job(32'hFFFF_F000, 100, 100, 0, 0, 100, 0, 0, 0, "addr_wrap");
    endtask

    task automatic test_reset_mid_burst();
        run_job(32'h0, 64, 100, 0, 0, 100, 0, 0, 10, "reset_mid");
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mig_awvalid_o, mig_arvalid_o, mig_wvalid_o, mig_wlast_o, mig_bready_o,
             busy_o, done_o, res_ready_o} !== 8'b0) begin
            n_fails++;
            $display("FAIL reset_mid ctrl: got %b expected 00000000", {mig_awvalid_o, mig_arvalid_o,
                     mig_wvalid_o, mig_wlast_o, mig_bready_o, busy_o, done_o, res_ready_o});
        end
        n_checks++;
        if (mig_addr_o !== '0 || mig_arwlen_o !== '0 || mig_wstrb_o !== '0 || mig_wdata_o !== '0) begin
            n_fails++;
            $display("FAIL reset_mid data: got addr=%h len=%0d expected 0", mig_addr_o, mig_arwlen_o);
        end
        start_i = 1'b0;
        res_valid_i = 1'b0;
        mig_awready_i = 1'b0;
        mig_wready_i = 1'b0;
        mig_bvalid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            n_checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fails++;
                $display("FAIL reset_mid after: got done=%b busy=%b expected 0/0", done_o, busy_o);
            end
        end
        run_job(32'h0000_8000, 20, 90, 1, 0, 100, 0, 0, 0, "after_reset");
    endtask

    task automatic test_random_jobs();
        for (int i = 0; i < 4; i++) begin
            run_job($urandom, $urandom_range(1, 200), $urandom_range(30, 100), $urandom_range(0, 1),
                    $urandom_range(0, 3), $urandom_range(30, 100), $urandom_range(0, 3), 5, 0, "random");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_i = 1'b0;
        base_addr_i = '0;
        row_cnt_i = '0;
        res_data_i = '0;
        res_valid_i = 1'b0;
        mig_awready_i = 1'b0;
        mig_wready_i = 1'b0;
        mig_bvalid_i = 1'b0;

        test_reset();
        test_single_burst();
        test_multi_burst();
        test_backpressure();
        test_zero_length();
        test_extra_input();
        test_burst_boundaries();
        test_reset_mid_burst();
        test_random_jobs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
